projectile_engine: RTL and testbench
====================================

Name: projectile_engine

Overview:
Parametrised multi-slot projectile (missile) engine for the Galaga display pipeline. It launches shots from the player ship position on fire-key presses and advances every live shot upward once per frame. It retires shots at the top of the screen and reports a per-pixel "projectile here" flag to the video generator for colour muxing. It extends the single fixed ship sprite to N independently moving objects with launch arbitration and rate limiting.

Parameters:
NSLOT, 4, number of projectile slots (1..16)
SPEED, 4, pixels moved upward per frame_tick (1..31)
COOLDOWN, 8, minimum frame_ticks between accepted launches (0..255; 0 = no limit)
PW, 2, projectile width in pixels
PH, 6, projectile height in pixels
XOFF, 4, launch x offset added to ship_x (centres shot on the 11-pixel ship)

Ports:
clk  in  1  system clock, the same domain as the VGA pixel counters
reset  in  1  asynchronous, active-high
frame_tick  in  1  one-clk pulse, once per frame, asserted during vertical blank
fire  in  1  fire key level, already synchronised to clk
ship_x  in  10  ship left edge, screen coordinates
ship_y  in  10  ship top edge, screen coordinates
x  in  10  current pixel column from the VGA controller
y  in  10  current pixel row from the VGA controller
pixel_on  out  1  registered; 1 when (x,y) of the previous clk lies inside any active projectile
active_mask  out  NSLOT  bit i = slot i live
fire_accepted  out  1  one-clk pulse on the tick a launch occurs

Behaviour:
- Reset (async) sets all slots inactive, all slot x/y to 0, cooldown counter to 0, pixel_on 0, fire_accepted 0, and fire_prev 1. The fire_prev value of 1 means a key held through reset does not fire.
- All state changes except pixel_on occur only on clk edges where frame_tick=1. On all other cycles the state holds.
- Fire edge: fire_req = fire & ~fire_prev, evaluated on the tick. fire_prev <= fire on every tick, so one press gives at most one launch and the key is sampled once per frame.
- Per tick, the steps are evaluated from pre-tick state in this order:
  1. Move: each active slot with y >= SPEED gets y <= y - SPEED. An active slot with y < SPEED is cleared to inactive on the same tick.
  2. Launch: a launch occurs when fire_req=1, cooldown==0, ship_y >= PH, and at least one slot is inactive after step 1.
     - The target is the lowest-index inactive slot; a slot freed in step 1 is eligible.
     - The slot gets x <= ship_x + XOFF (10-bit, no wrap check needed within the 640 range) and y <= ship_y - PH, and becomes active.
     - A newly launched slot does not move on its launch tick.
  3. Cooldown: on launch it is loaded with COOLDOWN. Otherwise, if nonzero, it decrements by 1.
- fire_accepted = 1 for exactly the clk of a launching tick, else 0.
- A rejected request (all slots full, cooldown active, or ship_y < PH) is dropped, not queued. Cooldown still decrements on that tick.
- Hit test: slot i hits when active_i & x>=px_i & x<px_i+PW & y>=py_i & y<py_i+PH. Compare at 11 bits to avoid overflow. pixel_on <= OR over slots, one clk latency. The caller delays its own colour path by one clk to match.
- Positions change only during blanking, so there is no mid-frame tearing.
- active_mask is a direct view of the slot valid bits, with zero latency from state.
- Widths: all coordinates are 10-bit unsigned, and no subtraction may underflow (guaranteed by the conditions above).

Decomposition:
- galaga_pkg: typedef coord_t (logic [9:0]); constants H_ACTIVE=640 and V_ACTIVE=480; a typedef struct for slot state {valid, x, y}.
- Sub-module projectile_slot: holds one slot's valid/x/y register, the move/retire logic, the launch load input, and the hit comparator.
- The top level instantiates NSLOT copies via generate and holds the priority encoder, fire edge detect, cooldown counter, and OR-reduce.

Test Plan:
1. Reset with fire held high, then 3 ticks with fire high -> no launch, active_mask=0000, fire_accepted never 1.
2. NSLOT=4, ship_x=320, ship_y=460, press fire on one tick -> slot0 at x=324, y=454, fire_accepted pulses once. After 2 more ticks slot0 y=446. Scanning (324..325, 446..451) gives pixel_on=1 one clk later. (323,446) and (326,446) give 0.
3. Press fire on 5 consecutive edges spaced 10 ticks apart (COOLDOWN=8) -> slots 0..3 fill in order; the 5th request is dropped with mask=1111 and fire_accepted=0.
4. Press fire again 3 ticks after an accepted launch -> rejected by cooldown. Press at 9 ticks -> accepted.
5. Slot at y=3 with SPEED=4, fire edge on the same tick with all other slots full -> slot retires and is immediately reloaded at y=454, mask unchanged at 1111, fire_accepted=1.
6. Assert reset mid-flight with 3 slots live -> mask=0 and pixel_on=0 asynchronously, cooldown=0. After release, the first new fire edge is accepted into slot0.

Source files
------------

// File: rtl/galaga_pkg.sv
// Shared types and constants for the Galaga display pipeline.
package galaga_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef logic [7:0] cool_t;

    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
    } slot_t;

    // True when p lies in [lo, lo+len); widened to 11 bits so lo+len cannot wrap.
    function automatic logic in_span(coord_t p, coord_t lo, int unsigned len);
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + 11'(len)));
    endfunction

endpackage

// File: rtl/projectile_engine_if.sv
// Bus between the video/game logic and the projectile engine.
interface projectile_engine_if #(
    parameter int unsigned NSLOT = 4
);
    logic                  frame_tick;
    logic                  fire;
    galaga_pkg::coord_t    ship_x;
    galaga_pkg::coord_t    ship_y;
    galaga_pkg::coord_t    x;
    galaga_pkg::coord_t    y;
    logic                  pixel_on;
    logic [NSLOT-1:0]      active_mask;
    logic                  fire_accepted;

    modport master (
        output frame_tick, fire, ship_x, ship_y, x, y,
        input  pixel_on, active_mask, fire_accepted
    );

    modport slave (
        input  frame_tick, fire, ship_x, ship_y, x, y,
        output pixel_on, active_mask, fire_accepted
    );
endinterface

// File: rtl/projectile_slot.sv
// One projectile: position/valid state, per-frame move and retire, launch load, hit test.
module projectile_slot
    import galaga_pkg::*;
#(
    parameter int unsigned SPEED = 4,
    parameter int unsigned PW    = 2,
    parameter int unsigned PH    = 6
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   tick_i,
    input  logic   load_i,
    input  coord_t load_x_i,
    input  coord_t load_y_i,
    input  coord_t x_i,
    input  coord_t y_i,
    output logic   valid_o,
    output logic   free_o,
    output logic   hit_o
);

    slot_t slot_q, slot_d;
    logic  retire;

    // A live shot too close to the top to move a full step leaves the screen this tick.
    assign retire = slot_q.valid && (slot_q.y < coord_t'(SPEED));

    // Next state: move or retire on the tick; a load overrides, so a fresh shot does not move.
    always_comb begin
        slot_d = slot_q;
        if (tick_i) begin
            if (slot_q.valid) begin
                if (retire) begin
                    slot_d.valid = 1'b0;
                end else begin
                    slot_d.y = slot_q.y - coord_t'(SPEED);
                end
            end
            if (load_i) begin
                slot_d.valid = 1'b1;
                slot_d.x     = load_x_i;
                slot_d.y     = load_y_i;
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid_o = slot_q.valid;
    // Free for a launch on this tick, counting a slot that retires on the same tick.
    assign free_o  = ~slot_q.valid | retire;
    assign hit_o   = slot_q.valid & in_span(x_i, slot_q.x, PW) & in_span(y_i, slot_q.y, PH);

endmodule

// File: rtl/projectile_engine.sv
// Multi-slot projectile engine: fire edge detect, launch arbitration, cooldown, pixel hit.
module projectile_engine
    import galaga_pkg::*;
#(
    parameter int unsigned NSLOT    = 4,
    parameter int unsigned SPEED    = 4,
    parameter int unsigned COOLDOWN = 8,
    parameter int unsigned PW       = 2,
    parameter int unsigned PH       = 6,
    parameter int unsigned XOFF     = 4
) (
    input logic                clk,
    input logic                reset,
    projectile_engine_if.slave bus
);

    logic             fire_prev_q, fire_prev_d;
    cool_t            cool_q, cool_d;
    logic             pixel_on_q, pixel_on_d;
    logic [NSLOT-1:0] valid;
    logic [NSLOT-1:0] free;
    logic [NSLOT-1:0] hit;
    logic [NSLOT-1:0] load_sel;
    logic             fire_req;
    logic             launch;
    coord_t           load_x;
    coord_t           load_y;

    assign fire_req = bus.fire & ~fire_prev_q;
    assign launch   = bus.frame_tick & fire_req & (cool_q == '0)
                    & (bus.ship_y >= coord_t'(PH)) & (|free);
    assign load_x   = bus.ship_x + coord_t'(XOFF);
    assign load_y   = bus.ship_y - coord_t'(PH);

    // Lowest-index free slot receives the launch.
    always_comb begin
        logic found;
        found    = 1'b0;
        load_sel = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (free[i] && !found) begin
                load_sel[i] = launch;
                found       = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        projectile_slot #(
            .SPEED (SPEED),
            .PW    (PW),
            .PH    (PH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .tick_i   (bus.frame_tick),
            .load_i   (load_sel[g]),
            .load_x_i (load_x),
            .load_y_i (load_y),
            .x_i      (bus.x),
            .y_i      (bus.y),
            .valid_o  (valid[g]),
            .free_o   (free[g]),
            .hit_o    (hit[g])
        );
    end

    // Next state: fire key sampled and cooldown stepped only on frame ticks.
    always_comb begin
        fire_prev_d = fire_prev_q;
        cool_d      = cool_q;
        pixel_on_d  = |hit;
        if (bus.frame_tick) begin
            fire_prev_d = bus.fire;
            if (launch) begin
                cool_d = cool_t'(COOLDOWN);
            end else if (cool_q != '0) begin
                cool_d = cool_q - cool_t'(1);
            end
        end
    end

    // Control registers; fire_prev resets high so a key held through reset does not fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_prev_q <= 1'b1;
            cool_q      <= '0;
            pixel_on_q  <= 1'b0;
        end else begin
            fire_prev_q <= fire_prev_d;
            cool_q      <= cool_d;
            pixel_on_q  <= pixel_on_d;
        end
    end

    assign bus.pixel_on      = pixel_on_q;
    assign bus.active_mask   = valid;
    assign bus.fire_accepted = launch;

endmodule

// File: tb/tb_projectile_engine.sv
// Directed, table-driven bench for projectile_engine (NSLOT=4, SPEED=4, COOLDOWN=8).
module tb_projectile_engine;
    import galaga_pkg::*;

    localparam int unsigned NSLOT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    projectile_engine_if #(.NSLOT(NSLOT)) bus ();

    projectile_engine #(
        .NSLOT    (NSLOT),
        .SPEED    (4),
        .COOLDOWN (8),
        .PW       (2),
        .PH       (6),
        .XOFF     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       fire;
        logic       acc;
        logic [3:0] mask;
    } vec_t;

    typedef struct {
        int   px;
        int   py;
        logic on;
    } probe_t;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t   vecs[14];
    probe_t probes[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame tick; fire_accepted is sampled during the tick cycle, mask after it.
    task automatic tick_check(input logic f, input logic exp_acc, input logic [3:0] exp_mask,
                              input string name);
        logic acc;
        @(negedge clk);
        bus.fire       = f;
        bus.frame_tick = 1'b1;
        #1 acc = bus.fire_accepted;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        check({name, ".acc"}, int'(acc), int'(exp_acc));
        check({name, ".mask"}, int'(bus.active_mask), int'(exp_mask));
    endtask

    task automatic idle_ticks(input int n, input string name);
        logic acc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.fire       = 1'b0;
            bus.frame_tick = 1'b1;
            #1 acc = bus.fire_accepted;
            @(negedge clk);
            bus.frame_tick = 1'b0;
            check($sformatf("%s.idle%0d", name, i), int'(acc), 0);
        end
    endtask

    task automatic press_after(input int n, input logic exp_acc, input logic [3:0] exp_mask,
                               input string name);
        idle_ticks(n, name);
        tick_check(1'b1, exp_acc, exp_mask, name);
    endtask

    // pixel_on is registered: drive (x,y), then read it on the following negedge.
    task automatic probe(input int px, input int py, input logic exp, input string name);
        @(negedge clk);
        bus.x = coord_t'(px);
        bus.y = coord_t'(py);
        @(negedge clk);
        check($sformatf("%s(%0d,%0d)", name, px, py), int'(bus.pixel_on), int'(exp));
        bus.x = '0;
        bus.y = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1 and 2 sequence, then cooldown rejection/acceptance (ship 320/460).
        vecs[0]  = '{1'b1, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000};
        vecs[3]  = '{1'b0, 1'b0, 4'b0000};
        vecs[4]  = '{1'b1, 1'b1, 4'b0001};  // slot0 at (324,454)
        vecs[5]  = '{1'b0, 1'b0, 4'b0001};
        vecs[6]  = '{1'b0, 1'b0, 4'b0001};  // slot0 now y=446
        vecs[7]  = '{1'b1, 1'b0, 4'b0001};  // 3 ticks after launch: cooldown rejects
        vecs[8]  = '{1'b0, 1'b0, 4'b0001};
        vecs[9]  = '{1'b0, 1'b0, 4'b0001};
        vecs[10] = '{1'b0, 1'b0, 4'b0001};
        vecs[11] = '{1'b0, 1'b0, 4'b0001};
        vecs[12] = '{1'b0, 1'b0, 4'b0001};
        vecs[13] = '{1'b1, 1'b1, 4'b0011};  // 9 ticks after launch: accepted into slot1

        probes[0] = '{324, 446, 1'b1};
        probes[1] = '{325, 446, 1'b1};
        probes[2] = '{324, 451, 1'b1};
        probes[3] = '{325, 451, 1'b1};
        probes[4] = '{323, 446, 1'b0};
        probes[5] = '{326, 446, 1'b0};
        probes[6] = '{324, 445, 1'b0};
        probes[7] = '{324, 452, 1'b0};

        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.fire       = 1'b1;
        bus.ship_x     = 10'd320;
        bus.ship_y     = 10'd460;
        bus.x          = '0;
        bus.y          = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst.mask", int'(bus.active_mask), 0);
        check("rst.pixel_on", int'(bus.pixel_on), 0);
        check("rst.acc", int'(bus.fire_accepted), 0);

        for (int i = 0; i < 7; i++) tick_check(vecs[i].fire, vecs[i].acc, vecs[i].mask,
                                               $sformatf("vec%0d", i));
        for (int i = 0; i < 8; i++) probe(probes[i].px, probes[i].py, probes[i].on, "hit");
        for (int i = 7; i < 14; i++) tick_check(vecs[i].fire, vecs[i].acc, vecs[i].mask,
                                                $sformatf("vec%0d", i));

        // Fill slots 2 and 3 ten ticks apart; the fifth request finds no free slot.
        press_after(9, 1'b1, 4'b0111, "fill2");
        press_after(9, 1'b1, 4'b1111, "fill3");
        press_after(9, 1'b0, 4'b1111, "full");

        // Fresh start; a ship too close to the top cannot launch.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.ship_y = 10'd5;
        tick_check(1'b0, 1'b0, 4'b0000, "low.pre");
        tick_check(1'b1, 1'b0, 4'b0000, "low.fire");
        bus.ship_y = 10'd460;
        tick_check(1'b0, 1'b0, 4'b0000, "b.pre");
        tick_check(1'b1, 1'b1, 4'b0001, "b.s0");
        press_after(9, 1'b1, 4'b0011, "b.s1");
        press_after(9, 1'b1, 4'b0111, "b.s2");

        // Asynchronous reset mid-flight with three live slots.
        probe(324, 454, 1'b1, "pre_rst");
        @(negedge clk);
        bus.x = 10'd324;
        bus.y = 10'd454;
        @(negedge clk);
        check("pre_rst.held_pixel", int'(bus.pixel_on), 1);
        #2 reset = 1'b1;
        #1;
        check("async.mask", int'(bus.active_mask), 0);
        check("async.pixel_on", int'(bus.pixel_on), 0);
        bus.x = '0;
        bus.y = '0;
        @(negedge clk);
        reset = 1'b0;
        // Immediate acceptance proves the cooldown was cleared.
        tick_check(1'b0, 1'b0, 4'b0000, "c.pre");
        tick_check(1'b1, 1'b1, 4'b0001, "c.s0");

        // Retire-and-reload: slot3 launched low enough to sit at y=3 after 9 moves.
        press_after(9, 1'b1, 4'b0011, "c.s1");
        press_after(9, 1'b1, 4'b0111, "c.s2");
        bus.ship_y = 10'd45;
        press_after(9, 1'b1, 4'b1111, "c.s3");
        bus.ship_y = 10'd460;
        probe(324, 39, 1'b1, "s3.launch");
        idle_ticks(9, "c.wait");
        check("s3.mask", int'(bus.active_mask), 15);
        probe(324, 3, 1'b1, "s3.top");
        probe(324, 8, 1'b1, "s3.bot");
        probe(324, 2, 1'b0, "s3.above");
        probe(324, 9, 1'b0, "s3.below");
        tick_check(1'b1, 1'b1, 4'b1111, "reload");
        probe(324, 454, 1'b1, "reload.pos");
        probe(325, 459, 1'b1, "reload.corner");
        probe(324, 3, 1'b0, "reload.old");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
